mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter that merges instruction-fetch and load/store request bundles onto one
// memory port, one outstanding transaction at a time. Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);
  // Handshake: a request is accepted in the cycle where mem_req and mem_addr_ok are both 1
  // (mirrored to the owner as *_addr_ok); its response is the single mem_data_ok cycle in WAIT.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;  // 1 = data side owns the latched bundle
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        w_any_req;
  logic        w_grant_data;
  logic        w_accept;

  assign w_any_req = inst_req | data_req;
  assign w_accept  = (r_state == S_IDLE) & w_any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_data;

  // On a tie the side that did not win the previous grant goes first.
  assign w_grant_data = (inst_req & data_req) ? ~r_last_data : data_req;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last_data <= 1'b1;
    end else if (w_accept) begin
      r_last_data <= w_grant_data;
    end
  end
`else
  assign w_grant_data = data_req;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner <= 1'b1;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_wstrb <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_owner <= w_grant_data;
      r_wr    <= w_grant_data ? data_wr    : inst_wr;
      r_size  <= w_grant_data ? data_size  : inst_size;
      r_wstrb <= w_grant_data ? data_wstrb : inst_wstrb;
      r_addr  <= w_grant_data ? data_addr  : inst_addr;
      r_wdata <= w_grant_data ? data_wdata : inst_wdata;
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_ADDR;
      end
      S_ADDR: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          inst_addr_ok = ~r_owner;
          data_addr_ok = r_owner;
          w_next       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_data_ok) begin
          inst_data_ok = ~r_owner;
          data_data_ok = r_owner;
          w_next       = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_wr     = r_wr;
  assign mem_size   = r_size;
  assign mem_wstrb  = r_wstrb;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign dbg_state  = r_state;

endmodule
